// File: rtl/tone_i2s_driver.sv
// tone_i2s_driver: square-wave tone generator feeding a fixed-rate I2S transmitter.
// Rev 1.0
`default_nettype none

module tone_i2s_driver #(
   parameter int VOL_SHIFT = 11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [19:0] note_div,
   input  logic [3:0]  vol,
   output logic        audio_mclk,
   output logic        audio_sck,
   output logic        audio_lrck,
   output logic        audio_sdin,
   output logic        tone_out
);

   logic [19:0] per_q;
   logic [19:0] tcnt;
   logic [8:0]  dcnt;
   logic [15:0] sreg_l;
   logic [15:0] sreg_r;

   logic        resting;
   logic        period_end;
   logic        tone;
   logic [15:0] amp;
   logic [15:0] sample;
   logic [3:0]  slot;
   logic [15:0] chan_word;
   logic        sdin_next;

   assign resting    = (per_q < 20'd2);
   assign period_end = (tcnt == (per_q - 20'd1));
   assign tone       = !resting && (tcnt < (per_q >> 1));
   assign tone_out   = tone;

   assign amp = 16'(vol) << VOL_SHIFT;

   always_comb begin
      sample = 16'd0;
      if (!resting && (vol != 4'd0)) begin
         sample = tone ? amp : (16'd0 - amp);
      end
   end

   // Both channels carry the same word; the slot index picks the bit MSB first.
   assign slot      = dcnt[7:4];
   assign chan_word = dcnt[8] ? sreg_r : sreg_l;
   assign sdin_next = chan_word[4'd15 - slot];

   always_ff @(posedge clk) begin
      if (rst) begin
         per_q      <= 20'd0;
         tcnt       <= 20'd0;
         dcnt       <= 9'd0;
         sreg_l     <= 16'd0;
         sreg_r     <= 16'd0;
         audio_mclk <= 1'b0;
         audio_sck  <= 1'b0;
         audio_lrck <= 1'b0;
         audio_sdin <= 1'b0;
      end else begin
         // A new period only takes effect at a boundary, so no period is ever truncated.
         if (resting || period_end) begin
            per_q <= note_div;
            tcnt  <= 20'd0;
         end else begin
            tcnt  <= tcnt + 20'd1;
         end

         dcnt <= dcnt + 9'd1;
         if (dcnt == 9'd511) begin
            sreg_l <= sample;
            sreg_r <= sample;
         end

         audio_mclk <= dcnt[1];
         audio_sck  <= dcnt[3];
         audio_lrck <= dcnt[8];
         audio_sdin <= sdin_next;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_tone_i2s_driver.sv
// tb_tone_i2s_driver: randomized stimulus against a time-based reference model of tone and I2S frames.
// Rev 1.0
`default_nettype none

module tb_tone_i2s_driver;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [19:0] note_div = 20'd0;
   logic [3:0]  vol = 4'd0;
   logic        audio_mclk, audio_sck, audio_lrck, audio_sdin, tone_out;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: elapsed cycles since reset, current period and its start time,
   // the word being transmitted this frame, and the registered output bits due next.
   int          c       = 0;
   int          m_per   = 0;
   int          m_start = 0;
   logic [15:0] word    = 16'd0;
   logic [3:0]  outq    = 4'd0;

   tone_i2s_driver #(.VOL_SHIFT(11)) dut (
      .clk        (clk),
      .rst        (rst),
      .note_div   (note_div),
      .vol        (vol),
      .audio_mclk (audio_mclk),
      .audio_sck  (audio_sck),
      .audio_lrck (audio_lrck),
      .audio_sdin (audio_sdin),
      .tone_out   (tone_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
   endtask

   // Called just after a falling edge with the inputs for the next rising edge in place.
   task automatic advance(input string tag);
      int          d, pos, amp_i;
      logic        tone_now, exp_tone;
      logic [15:0] samp;
      if (rst) begin
         c = 0; m_per = 0; m_start = 0; word = 16'd0; outq = 4'd0;
      end else begin
         d        = c % 512;
         pos      = c - m_start;
         tone_now = (m_per >= 2) && (pos < m_per / 2);
         amp_i    = int'(vol) * 2048;
         if (m_per < 2 || vol == 4'd0) samp = 16'd0;
         else if (tone_now)            samp = 16'(amp_i);
         else                          samp = 16'(-amp_i);
         outq[3] = 1'((d >> 1) & 1);
         outq[2] = 1'((d >> 3) & 1);
         outq[1] = 1'((d >> 8) & 1);
         outq[0] = 1'((int'(word) >> (15 - ((d >> 4) % 16))) & 1);
         if (m_per < 2 || pos == m_per - 1) begin
            m_per   = int'(note_div);
            m_start = c + 1;
         end
         if (d == 511) word = samp;
         c++;
      end
      @(posedge clk);
      @(negedge clk);
      exp_tone = (m_per >= 2) && ((c - m_start) < m_per / 2);
      check(tag, {27'd0, tone_out, audio_mclk, audio_sck, audio_lrck, audio_sdin},
            {27'd0, exp_tone, outq});
   endtask

   task automatic run(input int n, input int jitter_pct, input string tag);
      for (int i = 0; i < n; i++) begin
         if (int'($urandom_range(99)) < jitter_pct) note_div = 20'($urandom_range(300));
         advance(tag);
      end
   endtask

   initial begin
      bit hit;
      rst = 1'b1;
      repeat (3) advance("reset");

      rst = 1'b0; note_div = 20'd0; vol = 4'd15;
      run(2048, 0, "rest");

      note_div = 20'd100;
      run(3000, 0, "tone100");

      note_div = 20'd101;
      run(700, 0, "tone101");
      hit = 1'b0;
      for (int k = 0; k < 500 && !hit; k++) begin
         if (m_per == 101 && (c - m_start) == 20) hit = 1'b1;
         else advance("tone101_sync");
      end
      check("sync_tcnt20", 32'(hit), 32'd1);
      note_div = 20'd40;
      run(1000, 0, "tone40");

      note_div = 20'd1000; vol = 4'd1;
      run(3000, 0, "vol1");
      vol = 4'd0;
      run(2000, 0, "vol0");

      note_div = 20'd60;
      for (int i = 0; i < 2000; i++) begin
         vol = 4'($urandom_range(15));
         advance("vol_jitter");
      end
      run(2500, 30, "note_jitter");

      vol = 4'd15; note_div = 20'd100;
      run(900, 0, "pre_rst");
      hit = 1'b0;
      for (int k = 0; k < 600 && !hit; k++) begin
         if (c % 512 == 300) hit = 1'b1;
         else advance("rst_sync");
      end
      check("sync_dcnt300", 32'(hit), 32'd1);
      rst = 1'b1;
      advance("rst_pulse");
      check("rst_outs", {27'd0, tone_out, audio_mclk, audio_sck, audio_lrck, audio_sdin}, 32'd0);
      rst = 1'b0;
      run(1300, 0, "post_rst");

      for (int s = 0; s < 20; s++) begin
         note_div = ($urandom_range(3) == 0) ? 20'd0 : 20'($urandom_range(1500, 2));
         vol      = 4'($urandom_range(15, 1));
         run(int'($urandom_range(2200, 1200)), 0, "melody");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/tone_i2s_driver.md
TONE_I2S_DRIVER -- requirements
Module: tone_i2s_driver

Interface
REQ-001 Parameter: VOL_SHIFT, 11, left shift applied to vol to form square-wave amplitude.
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: note_div  input  20  tone period in clk cycles from the melody step counter; values 0 and 1 mean rest.
REQ-005 Port: vol  input  4  volume, unsigned; 0 means silent.
REQ-006 Port: audio_mclk  output  1  I2S master clock = clk/4.
REQ-007 Port: audio_sck  output  1  I2S bit clock = clk/16.
REQ-008 Port: audio_lrck  output  1  I2S word select = clk/512; 0 = left, 1 = right.
REQ-009 Port: audio_sdin  output  1  I2S serial data, MSB first.
REQ-010 Port: tone_out  output  1  raw square wave, for LED/buzzer debug.

Function
REQ-011 Tone period register per_q (20 bit) holds the active period; tone counter tcnt (20 bit) counts 0..per_q-1, then wraps to 0.
REQ-012 per_q loads note_div only on the cycle tcnt == per_q-1 (period boundary), or on any cycle while per_q < 2; no mid-period period changes.
REQ-013 While per_q < 2: tcnt held at 0, tone_out = 0, sample = 0.
REQ-014 While per_q >= 2: tone_out = 1 when tcnt < (per_q >> 1), else 0; odd per_q gives a longer low phase.
REQ-015 Amplitude amp = vol << VOL_SHIFT, zero-extended to 16 bits; max 15*2048 = 30720, no overflow at default.
REQ-016 Sample (16-bit signed): +amp when tone_out = 1; two's complement -amp when tone_out = 0 and per_q >= 2; 0 when resting or vol = 0.
REQ-017 Free-running 9-bit divider dcnt increments every cycle and wraps 511 -> 0.
REQ-018 audio_mclk = dcnt[1], audio_sck = dcnt[3], audio_lrck = dcnt[8]; each output registered, so each output lags its dcnt bit by one cycle consistently.
REQ-019 On dcnt == 511, the current sample loads into both the left and right shift registers; the same sample is sent on both channels.
REQ-020 Bit slot k = dcnt[7:4] (0..15) in each half frame; audio_sdin = bit (15-k) of the channel selected by dcnt[8].
REQ-021 audio_sdin changes only on sck falling edges (dcnt[3:0] == 15 -> 0) and is stable while audio_sck is high.
REQ-022 Sample latency: a note_div change is visible on tone_out within per_q+1 cycles and in audio_sdin at the next frame load (dcnt == 511).
REQ-023 note_div changing more than once inside one period: only the value present on the boundary cycle is used.
REQ-024 vol is sampled combinationally into the sample each cycle; only the frame-load value is transmitted.

Reset
REQ-025 With rst = 1 at a clk edge: per_q = 0, tcnt = 0, dcnt = 0, both shift registers = 0.
REQ-026 Outputs during and after reset: tone_out, audio_mclk, audio_sck, audio_lrck, audio_sdin = 0.
REQ-027 Reset mid-frame or mid-period aborts immediately with no partial sample. The first frame after reset transmits 0, and the first note loads on the cycle after rst deasserts.

Verification
REQ-028 Reset, then hold note_div = 0, vol = 15 for 2048 cycles -> tone_out = 0 and audio_sdin = 0 throughout; lrck toggles every 256 cycles.
REQ-029 Set note_div = 100, vol = 15 -> tone_out high 50 cycles, low 50 cycles, repeating. Captured I2S words are only 0x7800 or 0x8800, identical on L and R.
REQ-030 Set note_div = 101 -> tone_out high 50, low 51; change to 40 at tcnt = 20 -> the current 101-cycle period completes before the 40-cycle period starts.
REQ-031 Set note_div = 1000, vol = 1, then vol = 0 -> words 0x0800/0xF800, then 0x0000.
REQ-032 Assert rst for 1 cycle at dcnt = 300 during a tone -> all outputs 0 next cycle; the divider restarts from 0; the first post-reset frame is 0x0000.
REQ-033 Drive note_div through the 64-step melody sequence, one step per 65536 cycles -> each tone_out period equals the step's note_div, and steps with note_div = 0 produce silence.
